wptr_full_level: RTL and testbench
==================================

// Module: wptr_full_level
// PURPOSE
//  Write-domain pointer/status block of the async FIFO, mirroring the read-side pointer/empty logic.
//  Keeps the binary and Gray write pointers and drives the write address into the dual-port memory.
//  From the 2-flop-synchronised Gray read pointer it produces full, almost-full, fill level and a sticky overflow flag.
//  Sits entirely in the wclk domain; wptr is exported to the read-side synchroniser.
// PARAMETERS
//  N          4   address width; FIFO depth = 2**N; N >= 2
//  AF_THRESH  14  almost-full asserts when level >= AF_THRESH; legal 1..2**N
// PORTS
//  wclk          in   1    write clock; all state on rising edge
//  wrst          in   1    asynchronous, active-high reset
//  winc          in   1    write request; accepted only when wfull==0
//  wq2_rptr      in   N+1  Gray read pointer, already synchronised into wclk
//  wovf_clr      in   1    clears sticky overflow flag
//  waddr         out  N    memory write address = bin[N-1:0]
//  wptr          out  N+1  registered Gray write pointer, to read-side synchroniser
//  wfull         out  1    registered full flag
//  walmost_full  out  1    registered almost-full flag
//  wlevel        out  N+1  registered fill level 0..2**N (write-side view)
//  wovf          out  1    sticky: a write was attempted while full
// BEHAVIOUR
//  Reset (wrst=1, async): bin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0.
//   All take effect immediately, mid-operation included; in-flight write is lost. Deassertion is synchronised upstream.
//  Combinational, per cycle:
//   bnext = bin + (winc & ~wfull), modulo 2**(N+1).
//   gnext = (bnext>>1) ^ bnext.
//   rbin  = Gray-to-binary of wq2_rptr (MSB-down XOR prefix).
//   full_w  = gnext == {~wq2_rptr[N:N-1], wq2_rptr[N-2:0]}.
//   level_w = bnext - rbin, modulo 2**(N+1); max 2**N.
//   af_w    = level_w >= AF_THRESH.
//  Each wclk edge: bin<=bnext, wptr<=gnext, wfull<=full_w, wlevel<=level_w, walmost_full<=af_w.
//  Latency:
//   An accepted write moves waddr/wptr and the flags on the same edge (zero added latency).
//   Read-side frees appear 2 wclk after the read pointer changes, via the external synchroniser.
//  Full is pessimistic:
//   It deasserts only once the synced read pointer moves.
//   It updates every cycle, even when winc=0.
//  Write while full: the pointer and address hold, no write is accepted, and wovf<=1.
//  wovf priority: set (winc&wfull) beats wovf_clr in the same cycle; otherwise wovf_clr clears it.
//  Wrap-around:
//   bin wraps 2**(N+1)-1 -> 0 with no special case.
//   waddr wraps every 2**N writes.
//   The extra MSB distinguishes full from empty.
//  wq2_rptr is assumed Gray-coherent (one bit changes per sync). No checking is done here.
//  Memory write enable = winc & ~wfull, generated by the FIFO top level, not here.
// STRUCTURE
//  Shared package fifo_pkg: N default, bin2gray/gray2bin functions, depth constant.
//  One sub-module: gray2bin (parameter W=N+1, combinational), also reused by the read side for its level.
//  Everything else is flat: one sequential block for pointers and flags, one for wovf.
// TESTING (N=4, AF_THRESH=14)
//  1 Reset: pulse wrst mid-traffic -> all outputs 0 asynchronously, before the next wclk edge.
//  2 Fill: wq2_rptr=0, winc=1 for 16 cycles.
//    After edge 14: walmost_full=1, wlevel=14.
//    After edge 16: wfull=1, wlevel=16, waddr=0, wptr=5'b11000.
//  3 Overflow: winc=1 on cycle 17 -> wptr stays 5'b11000, wovf=1.
//    wovf_clr=1 with winc=0 -> wovf=0.
//    winc=1 and wovf_clr=1 while full -> wovf=1.
//  4 Drain: from full, drive wq2_rptr=5'b00110 (bin 4), winc=0.
//    Next edge: wfull=0, wlevel=12, walmost_full=0.
//  5 Wrap: write/read traffic takes bin 31 -> 0.
//    wptr goes 5'b10000 -> 5'b00000; wfull/wlevel stay correct across the wrap.
//    Empty (wlevel=0) is never flagged full.
//  6 Simultaneous: winc=1 on the same edge the synced read pointer advances by 1 while full-1 -> wfull=0, wlevel unchanged.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and Gray code helpers
package fifo_pkg;

    localparam int N_DEF = 4;
    localparam int DEPTH_DEF = 2 ** N_DEF;

    // Widest pointer supported by the helpers; narrower pointers are zero-extended.
    localparam int PTR_MAX_W = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter, shared by both FIFO pointer blocks
module gray2bin #(
    parameter int W = fifo_pkg::N_DEF + 1
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/wptr_full_level.sv
// rtl/wptr_full_level.sv - async FIFO write-side pointers, full/almost-full, level and overflow
module wptr_full_level
    import fifo_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int AF_THRESH = 14
) (
    input  logic         wclk,
    input  logic         wrst,
    input  logic         winc,
    input  logic [N:0]   wq2_rptr,
    input  logic         wovf_clr,
    output logic [N-1:0] waddr,
    output logic [N:0]   wptr,
    output logic         wfull,
    output logic         walmost_full,
    output logic [N:0]   wlevel,
    output logic         wovf
);

    logic [N:0] bin;
    logic [N:0] bnext;
    logic [N:0] gnext;
    logic [N:0] rbin;
    logic [N:0] level_w;
    logic       wr_ok;
    logic       full_w;
    logic       af_w;

    gray2bin #(.W(N + 1)) u_rptr_bin (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    assign wr_ok   = winc & ~wfull;
    assign bnext   = bin + {{N{1'b0}}, wr_ok};
    assign gnext   = (bnext >> 1) ^ bnext;
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_w  = (gnext == {~wq2_rptr[N:N-1], wq2_rptr[N-2:0]});
    assign level_w = bnext - rbin;
    assign af_w    = 32'(level_w) >= AF_THRESH;
    assign waddr   = bin[N-1:0];

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            bin          <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            bin          <= bnext;
            wptr         <= gnext;
            wfull        <= full_w;
            wlevel       <= level_w;
            walmost_full <= af_w;
        end
    end

    // A rejected write in the same cycle as a clear still leaves the flag set.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wovf <= 1'b0;
        end else if (winc && wfull) begin
            wovf <= 1'b1;
        end else if (wovf_clr) begin
            wovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_full_level.sv
// tb/tb_wptr_full_level.sv - self-checking bench for wptr_full_level
module tb_wptr_full_level;

    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int MOD   = 32;

    logic         wclk = 1'b0;
    logic         wrst = 1'b1;
    logic         winc = 1'b0;
    logic         wovf_clr = 1'b0;
    logic [N:0]   wq2_rptr = '0;
    logic [N-1:0] waddr;
    logic [N:0]   wptr;
    logic         wfull;
    logic         walmost_full;
    logic [N:0]   wlevel;
    logic         wovf;

    wptr_full_level #(.N(N), .AF_THRESH(AF)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    always #5 wclk = ~wclk;

    int tests = 0;
    int fails = 0;

    // Reference model: counts of writes and reads, everything else derived arithmetically.
    int m_w, m_r, m_level;
    bit m_full, m_af, m_ovf;

    typedef struct {
        bit inc;
        int rbin;
        bit clr;
        int level;
        bit full;
        bit af;
        bit ovf;
        int addr;
        int gptr;
    } vec_t;

    vec_t tbl[20];

    function automatic int to_gray(int b);
        int x;
        x = b % MOD;
        return x ^ (x >> 1);
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_r = 0; m_level = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #1 wrst = 1'b1;
        winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
        model_reset();
        #2 wrst = 1'b0;
    endtask

    task automatic check_model(string tag);
        check({tag, " waddr"}, int'(waddr), m_w % DEPTH);
        check({tag, " wptr"}, int'(wptr), to_gray(m_w));
        check({tag, " wlevel"}, int'(wlevel), m_level);
        check({tag, " wfull"}, int'(wfull), int'(m_full));
        check({tag, " walmost_full"}, int'(walmost_full), int'(m_af));
        check({tag, " wovf"}, int'(wovf), int'(m_ovf));
    endtask

    task automatic step(bit inc, int rcnt, bit clr, string tag);
        bit acc;
        winc     = inc;
        wq2_rptr = (N+1)'(to_gray(rcnt));
        wovf_clr = clr;
        acc      = inc && !m_full;
        m_ovf    = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_w      = (m_w + int'(acc)) % MOD;
        m_r      = rcnt % MOD;
        m_level  = (m_w - m_r + MOD) % MOD;
        m_full   = (m_level == DEPTH);
        m_af     = (m_level >= AF);
        @(posedge wclk);
        #1;
        check_model(tag);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1'b1, 0, 1'b0, i + 1, (i == 15), (i + 1 >= AF), 1'b0, (i + 1) % DEPTH, to_gray(i + 1)};
        end
        tbl[16] = '{1'b1, 0, 1'b0, 16, 1'b1, 1'b1, 1'b1, 0, 24};
        tbl[17] = '{1'b0, 0, 1'b1, 16, 1'b1, 1'b1, 1'b0, 0, 24};
        tbl[18] = '{1'b1, 0, 1'b1, 16, 1'b1, 1'b1, 1'b1, 0, 24};
        tbl[19] = '{1'b0, 4, 1'b0, 12, 1'b0, 1'b0, 1'b1, 0, 24};

        model_reset();
        #2;
        check("reset wlevel", int'(wlevel), 0);
        check("reset wptr", int'(wptr), 0);
        #20 wrst = 1'b0;

        // Fill, overflow, clear, drain from a fresh reset
        do_reset();
        for (int i = 0; i < 20; i++) begin
            winc     = tbl[i].inc;
            wq2_rptr = (N+1)'(to_gray(tbl[i].rbin));
            wovf_clr = tbl[i].clr;
            @(posedge wclk);
            #1;
            check($sformatf("vec%0d wlevel", i), int'(wlevel), tbl[i].level);
            check($sformatf("vec%0d wfull", i), int'(wfull), int'(tbl[i].full));
            check($sformatf("vec%0d walmost_full", i), int'(walmost_full), int'(tbl[i].af));
            check($sformatf("vec%0d wovf", i), int'(wovf), int'(tbl[i].ovf));
            check($sformatf("vec%0d waddr", i), int'(waddr), tbl[i].addr);
            check($sformatf("vec%0d wptr", i), int'(wptr), tbl[i].gptr);
        end

        // Asynchronous reset mid-traffic, observed before the next clock edge
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0, "pre-reset");
        step(1'b1, 0, 1'b0, "pre-reset");
        #2 wrst = 1'b1;
        #1;
        check("async wptr", int'(wptr), 0);
        check("async waddr", int'(waddr), 0);
        check("async wlevel", int'(wlevel), 0);
        check("async wfull", int'(wfull), 0);
        check("async walmost_full", int'(walmost_full), 0);
        check("async wovf", int'(wovf), 0);
        wrst = 1'b0;
        model_reset();
        winc = 1'b0;

        // Write and read on the same edge while one short of full
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b1, 0, 1'b0, "to15");
        step(1'b1, 1, 1'b0, "simul");
        check("simul wlevel", int'(wlevel), 15);
        check("simul wfull", int'(wfull), 0);

        // Pointer wrap with a shallow fill, then fully drained
        do_reset();
        step(1'b1, 0, 1'b0, "wrap-init");
        for (int k = 0; k < 40; k++) begin
            step(1'b1, k, 1'b0, "wrap");
            if (m_w == 31) check("wrap wptr before", int'(wptr), 5'b10000);
            if (m_w == 0)  check("wrap wptr after", int'(wptr), 5'b00000);
        end
        step(1'b0, m_w, 1'b0, "empty");
        check("empty wlevel", int'(wlevel), 0);
        check("empty wfull", int'(wfull), 0);

        // Randomised traffic with alternating write-heavy / read-heavy phases
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bit inc, clr;
            int r;
            bit wr_heavy;
            wr_heavy = ((c / 60) % 2) == 0;
            inc = wr_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 7) == 0);
            r = m_r;
            if (((m_w - m_r + MOD) % MOD) > 0 &&
                (wr_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0)))
                r = (m_r + 1) % MOD;
            step(inc, r, clr, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
